// File: rtl/pulse_trig_pkg.sv
// Shared definitions for the pulse trigger processor.
//   - One-hot FSM state indices and the state enum built from them.
//   - Bit positions and widths of the trigger-info word and the trigger record.
//   - trig_length encodings.
//   - Default channel count and a helper that packs a trigger record.
package pulse_trig_pkg;

   localparam int unsigned NumChanDefault = 5;

   // One-hot state bit positions
   localparam int unsigned StIdleIdx    = 0;
   localparam int unsigned StWaitAcqIdx = 1;
   localparam int unsigned StStoreIdx   = 2;
   localparam int unsigned StDrainIdx   = 3;

   typedef enum logic [3:0] {
      StIdle    = 4'(1 << StIdleIdx),
      StWaitAcq = 4'(1 << StWaitAcqIdx),
      StStore   = 4'(1 << StStoreIdx),
      StDrain   = 4'(1 << StDrainIdx)
   } pt_state_e;

   // Trigger length encodings
   typedef enum logic [1:0] {
      TrigLenNone  = 2'b00,
      TrigLenShort = 2'b01,
      TrigLenLong  = 2'b10,
      TrigLenMixed = 2'b11
   } trig_len_e;

   // Word widths
   localparam int unsigned RecW = 128;

   // Field widths shared by the trigger-info word and the record
   localparam int unsigned TsW   = 44;
   localparam int unsigned NumW  = 24;
   localparam int unsigned LenW  = 2;
   localparam int unsigned MaskW = 5;

   // Trigger-info word layout: {58'd0, length, trig_num, timestamp}
   localparam int unsigned TrigTsLsb  = 0;
   localparam int unsigned TrigNumLsb = 44;
   localparam int unsigned TrigLenLsb = 68;
   localparam int unsigned TrigUsedW  = 70;

   // Record layout: {52'd0, tmo, done_mask, length, trig_num, timestamp}
   localparam int unsigned RecTsLsb   = 0;
   localparam int unsigned RecNumLsb  = 44;
   localparam int unsigned RecLenLsb  = 68;
   localparam int unsigned RecMaskLsb = 70;
   localparam int unsigned RecTmoBit  = 75;

   function automatic logic [RecW-1:0] pack_record(input logic [TsW-1:0]   ts,
                                                   input logic [NumW-1:0]  num,
                                                   input logic [LenW-1:0]  len,
                                                   input logic [MaskW-1:0] mask,
                                                   input logic             tmo);
      logic [RecW-1:0] rec;
      rec                         = '0;
      rec[RecTsLsb   +: TsW]      = ts;
      rec[RecNumLsb  +: NumW]     = num;
      rec[RecLenLsb  +: LenW]     = len;
      rec[RecMaskLsb +: MaskW]    = mask;
      rec[RecTmoBit]              = tmo;
      return rec;
   endfunction

endpackage

// File: rtl/pulse_trigger_processor.sv
// Pulse trigger processor.
// Pops trigger-info words from the first-word-fall-through Pulse Trigger FIFO, snapshots the
// enabled-channel mask, waits for every enabled channel to report acquisition complete (or for
// the programmable timeout), then offers one trigger record to the readout record FIFO.
//
// Ports:
//   clk                 40 MHz TTC clock
//   reset               synchronous, active-high
//   reset_counters_i    clears both status counters (wins over a same-cycle increment)
//   trig_fifo_valid_i   FIFO non-empty; trig_fifo_data_i is the head word
//   trig_fifo_data_i    {58'd0, length[1:0], trig_num[23:0], timestamp[43:0]}
//   trig_fifo_rd_o      pop strobe, combinational in IDLE
//   chan_en_i           enabled channels
//   chan_acq_done_i     per-channel one-cycle acquisition-complete pulses
//   acq_timeout_i       timeout in clk cycles from the pop; 0 disables
//   rec_valid_o/ready_i record handshake; rec_data_o held stable while stalled
//   trig_proc_count_o   records emitted
//   timeout_count_o     records emitted with the timeout flag set
//   state_o             one-hot FSM state
module pulse_trigger_processor
   import pulse_trig_pkg::*;
#(
   parameter int unsigned NCHAN = NumChanDefault,
   parameter int unsigned TMO_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reset_counters_i,
   input  logic             trig_fifo_valid_i,
   input  logic [RecW-1:0]  trig_fifo_data_i,
   output logic             trig_fifo_rd_o,
   input  logic [NCHAN-1:0] chan_en_i,
   input  logic [NCHAN-1:0] chan_acq_done_i,
   input  logic [TMO_W-1:0] acq_timeout_i,
   output logic             rec_valid_o,
   input  logic             rec_ready_i,
   output logic [RecW-1:0]  rec_data_o,
   output logic [31:0]      trig_proc_count_o,
   output logic [31:0]      timeout_count_o,
   output logic [3:0]       state_o
);

   localparam logic [TMO_W-1:0] TmoOne = TMO_W'(1);

   pt_state_e        state_q, state_d;
   logic [NCHAN-1:0] en_q, en_d;
   logic [NCHAN-1:0] done_q, done_d;
   logic [TMO_W-1:0] timer_q, timer_d;
   logic [TsW-1:0]   ts_q, ts_d;
   logic [NumW-1:0]  num_q, num_d;
   trig_len_e        len_q, len_d;
   logic [RecW-1:0]  rec_q, rec_d;
   logic [31:0]      proc_cnt_q, proc_cnt_d;
   logic [31:0]      tmo_cnt_q, tmo_cnt_d;

   logic [NCHAN-1:0] done_upd;
   logic [TMO_W-1:0] timer_inc;
   logic             tmo_hit;
   logic             rec_hs;
   logic             unused_trig_hi;

   // Upper bits of the trigger word are reserved zeros
   assign unused_trig_hi = ^trig_fifo_data_i[RecW-1:TrigUsedW];

   // Done pulses from channels outside the snapshot are dropped here
   assign done_upd  = done_q | (chan_acq_done_i & en_q);
   assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TmoOne;

   // timer_inc is the number of cycles elapsed since the pop (pop cycle = 0), so this fires
   // acq_timeout cycles after the pop lands in STORE. The >= covers acq_timeout == 1, whose
   // deadline is already behind us on the first WAIT_ACQ cycle.
   assign tmo_hit = (acq_timeout_i != '0) && (timer_inc >= (acq_timeout_i - TmoOne));

   assign rec_hs = (state_q == StStore) && rec_ready_i;

   always_comb begin
      state_d        = state_q;
      en_d           = en_q;
      done_d         = done_q;
      timer_d        = timer_q;
      ts_d           = ts_q;
      num_d          = num_q;
      len_d          = len_q;
      rec_d          = rec_q;
      trig_fifo_rd_o = 1'b0;

      unique case (state_q)
         StIdle: begin
            trig_fifo_rd_o = trig_fifo_valid_i;
            if (trig_fifo_valid_i) begin
               ts_d    = trig_fifo_data_i[TrigTsLsb +: TsW];
               num_d   = trig_fifo_data_i[TrigNumLsb +: NumW];
               len_d   = trig_len_e'(trig_fifo_data_i[TrigLenLsb +: LenW]);
               en_d    = chan_en_i;
               // A done pulse coincident with the pop already counts
               done_d  = chan_acq_done_i & chan_en_i;
               timer_d = '0;
               if (chan_en_i == '0) begin
                  // Nothing to wait for: record goes out next cycle
                  state_d = StStore;
                  rec_d   = pack_record(trig_fifo_data_i[TrigTsLsb +: TsW],
                                        trig_fifo_data_i[TrigNumLsb +: NumW],
                                        trig_fifo_data_i[TrigLenLsb +: LenW],
                                        '0, 1'b0);
               end else begin
                  state_d = StWaitAcq;
               end
            end
         end

         StWaitAcq: begin
            done_d  = done_upd;
            timer_d = timer_inc;
            // Completion is tested first so it wins over a same-cycle timeout
            if (done_upd == en_q) begin
               state_d = StStore;
               rec_d   = pack_record(ts_q, num_q, len_q, MaskW'(done_upd), 1'b0);
            end else if (tmo_hit) begin
               state_d = StStore;
               rec_d   = pack_record(ts_q, num_q, len_q, MaskW'(done_upd), 1'b1);
            end
         end

         StStore: begin
            if (rec_ready_i) begin
               state_d = StDrain;
               rec_d   = '0;
            end
         end

         // One idle cycle lets the FWFT head word settle before the next pop
         StDrain: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
            rec_d   = '0;
         end
      endcase
   end

   always_comb begin
      proc_cnt_d = proc_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      if (reset_counters_i) begin
         proc_cnt_d = '0;
         tmo_cnt_d  = '0;
      end else if (rec_hs) begin
         proc_cnt_d = proc_cnt_q + 32'd1;
         tmo_cnt_d  = tmo_cnt_q + {31'd0, rec_q[RecTmoBit]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         en_q       <= '0;
         done_q     <= '0;
         timer_q    <= '0;
         ts_q       <= '0;
         num_q      <= '0;
         len_q      <= TrigLenNone;
         rec_q      <= '0;
         proc_cnt_q <= '0;
         tmo_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         en_q       <= en_d;
         done_q     <= done_d;
         timer_q    <= timer_d;
         ts_q       <= ts_d;
         num_q      <= num_d;
         len_q      <= len_d;
         rec_q      <= rec_d;
         proc_cnt_q <= proc_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
      end
   end

   assign rec_valid_o       = (state_q == StStore);
   assign rec_data_o        = rec_q;
   assign trig_proc_count_o = proc_cnt_q;
   assign timeout_count_o   = tmo_cnt_q;
   assign state_o           = state_q;

endmodule

// File: tb/tb_pulse_trigger_processor.sv
// Bench for pulse_trigger_processor: directed scenarios plus randomized triggers. The driver
// computes each expected record (contents and the cycle it must appear) from per-channel done
// times and the timeout, and queues it; a negedge monitor pops and compares records and tracks
// the status counters.
module tb_pulse_trigger_processor;
   import pulse_trig_pkg::*;

   localparam int Never = 1000000;

   typedef struct {
      logic [127:0] data;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         reset_counters = 1'b0;
   logic         trig_fifo_valid = 1'b0;
   logic [127:0] trig_fifo_data = '0;
   logic         trig_fifo_rd;
   logic [4:0]   chan_en = '0;
   logic [4:0]   chan_acq_done = '0;
   logic [15:0]  acq_timeout = '0;
   logic         rec_valid;
   logic         rec_ready = 1'b0;
   logic [127:0] rec_data;
   logic [31:0]  trig_proc_count;
   logic [31:0]  timeout_count;
   logic [3:0]   state;

   int   checks = 0;
   int   errors = 0;
   int   cyc_now = 0;
   int   pa[5];
   bit   shown = 1'b0;
   bit   rc_at_hs = 1'b0;
   bit   mon_en = 1'b0;
   int   idle_at = 0;
   exp_t sb_q[$];

   pulse_trigger_processor #(
      .NCHAN(5),
      .TMO_W(16)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .reset_counters_i  (reset_counters),
      .trig_fifo_valid_i (trig_fifo_valid),
      .trig_fifo_data_i  (trig_fifo_data),
      .trig_fifo_rd_o    (trig_fifo_rd),
      .chan_en_i         (chan_en),
      .chan_acq_done_i   (chan_acq_done),
      .acq_timeout_i     (acq_timeout),
      .rec_valid_o       (rec_valid),
      .rec_ready_i       (rec_ready),
      .rec_data_o        (rec_data),
      .trig_proc_count_o (trig_proc_count),
      .timeout_count_o   (timeout_count),
      .state_o           (state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_now <= cyc_now + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_now);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] mk_word(input logic [1:0] len, input logic [23:0] num,
                                            input logic [43:0] ts);
      return {58'd0, len, num, ts};
   endfunction

   function automatic logic [127:0] rnd_word();
      return mk_word(2'($urandom), 24'($urandom), 44'({$urandom, $urandom}));
   endfunction

   // One trigger: from the cycle after the previous handshake up to and including this
   // trigger's handshake. pa[] holds each enabled channel's done-pulse offset from the pop
   // (-1 = never). If show_next is set, w_next is presented on the FIFO after the pop.
   task automatic do_trig(input logic [127:0] w, input logic [4:0] en, input int t_val,
                          input int stall, input int gap, input bit show_next,
                          input logic [127:0] w_next);
      int         c_done, t_done, t_tmo, s, p, h, k, first;
      logic [4:0] mask, sched, noise;
      bit         tmo;
      exp_t       e;

      // Completion time = latest enabled done offset
      c_done = 0;
      for (int ch = 0; ch < 5; ch++) begin
         if (en[ch] && pa[ch] < 0) c_done = Never;
         else if (en[ch] && pa[ch] > c_done) c_done = pa[ch];
      end
      mask = '0;
      tmo  = 1'b0;
      if (en == '0) begin
         s = 1;
      end else begin
         // Earliest record is two cycles after the pop; completion shows one cycle later
         t_done = (c_done == Never) ? Never : ((c_done + 1 > 2) ? c_done + 1 : 2);
         t_tmo  = (t_val == 0) ? Never : ((t_val > 2) ? t_val : 2);
         if (t_done <= t_tmo) begin
            s    = t_done;
            mask = en;
         end else begin
            s   = t_tmo;
            tmo = 1'b1;
            for (int ch = 0; ch < 5; ch++)
               if (en[ch] && pa[ch] >= 0 && pa[ch] <= s - 1) mask[ch] = 1'b1;
         end
      end

      first = cyc_now + 1;
      if (shown) p = idle_at;
      else p = (first + gap > idle_at) ? first + gap : idle_at;
      h = p + s + stall;
      e.data = {52'd0, tmo, mask, w[69:0]};
      e.cyc  = p + s;

      for (int c = first; c <= h; c++) begin
         tick();
         k = c - p;
         acq_timeout    = 16'(t_val);
         reset_counters = (rc_at_hs && c == h) ? 1'b1 : ($urandom_range(0, 15) == 0);
         if (c >= p + s) rec_ready = (c >= h);
         else rec_ready = 1'($urandom);
         noise = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
         sched = '0;
         for (int ch = 0; ch < 5; ch++)
            if (en[ch] && pa[ch] == k) sched[ch] = 1'b1;
         if (k < 0) begin
            trig_fifo_valid = shown || (c >= first + gap);
            trig_fifo_data  = w;
            chan_en         = 5'($urandom);
            chan_acq_done   = noise;
         end else if (k == 0) begin
            trig_fifo_valid = 1'b1;
            trig_fifo_data  = w;
            chan_en         = en;
            chan_acq_done   = sched | (noise & ~en);
            sb_q.push_back(e);
         end else begin
            trig_fifo_valid = show_next;
            trig_fifo_data  = show_next ? w_next : {4{$urandom}};
            chan_en         = 5'($urandom);
            chan_acq_done   = sched | (noise & ~en);
         end
         #1;
         check("fifo_rd", 128'(trig_fifo_rd), 128'(k == 0));
      end
      idle_at  = h + 2;
      shown    = show_next;
      rc_at_hs = 1'b0;
   endtask

   // Monitor: record ordering/contents/timing, hold during stall, DRAIN, counters
   exp_t        cur_e;
   bit          cur_v = 1'b0;
   bit          prev_hs = 1'b0;
   logic [31:0] exp_cnt = '0;
   logic [31:0] exp_tcnt = '0;

   always @(negedge clk) begin
      if (mon_en) begin
         check("proc_count", 128'(trig_proc_count), 128'(exp_cnt));
         check("timeout_count", 128'(timeout_count), 128'(exp_tcnt));
         check("state_onehot", 128'($onehot(state)), 128'(1));
         if (prev_hs) begin
            check("drain_valid", 128'(rec_valid), 128'(0));
            check("drain_data", rec_data, 128'(0));
         end
         if (rec_valid && !cur_v) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_record: got %0h expected none (cycle %0d)",
                        rec_data, cyc_now);
            end else begin
               cur_e = sb_q.pop_front();
               check("rec_cycle", 128'(cyc_now), 128'(cur_e.cyc));
               check("rec_data", rec_data, cur_e.data);
            end
         end else if (rec_valid) begin
            check("rec_hold", rec_data, cur_e.data);
         end
         cur_v = rec_valid;
         if (reset) begin
            exp_cnt  = '0;
            exp_tcnt = '0;
            cur_v    = 1'b0;
            prev_hs  = 1'b0;
         end else begin
            if (reset_counters) begin
               exp_cnt  = '0;
               exp_tcnt = '0;
            end else if (rec_valid && rec_ready) begin
               exp_cnt  = exp_cnt + 32'd1;
               exp_tcnt = exp_tcnt + {31'd0, cur_e.data[75]};
            end
            prev_hs = rec_valid && rec_ready;
         end
      end
   end

   initial begin
      logic [127:0] w, w_next, wa, wb, wc;
      logic [4:0]   en;
      int           t_val, stall, gap, p;
      bit           show;

      repeat (3) tick();
      reset = 1'b0;
      #1;
      check("rst_state", 128'(state), 128'(StIdle));
      check("rst_valid", 128'(rec_valid), 128'(0));
      check("rst_data", rec_data, 128'(0));
      check("rst_count", 128'(trig_proc_count), 128'(0));
      check("rst_tmo_count", 128'(timeout_count), 128'(0));
      check("rst_rd", 128'(trig_fifo_rd), 128'(0));
      idle_at = cyc_now + 1;
      mon_en  = 1'b1;

      // All enabled channels complete at staggered times
      pa = '{3, -1, 5, -1, 9};
      do_trig(mk_word(TrigLenShort, 24'd7, 44'h123), 5'b10101, 0, 0, 0, 1'b0, '0);
      // Timeout with only ch0 done
      pa = '{2, -1, -1, -1, -1};
      do_trig(rnd_word(), 5'b00011, 10, 0, 1, 1'b0, '0);
      // No channels enabled
      pa = '{-1, -1, -1, -1, -1};
      do_trig(rnd_word(), 5'b00000, 0, 0, 0, 1'b0, '0);
      // Single channel; disabled-channel pulses arrive as noise
      pa = '{6, -1, -1, -1, -1};
      do_trig(rnd_word(), 5'b00001, 0, 0, 2, 1'b0, '0);
      // 20-cycle stall with the next word already waiting
      wa = rnd_word();
      pa = '{1, 4, -1, -1, -1};
      do_trig(rnd_word(), 5'b00011, 0, 20, 0, 1'b1, wa);
      // Three back-to-back triggers, everything done in the pop cycle
      wb = rnd_word();
      wc = rnd_word();
      pa = '{0, 0, 0, 0, 0};
      do_trig(wa, 5'b11111, 0, 0, 0, 1'b1, wb);
      do_trig(wb, 5'b11111, 0, 0, 0, 1'b1, wc);
      rc_at_hs = 1'b1;
      do_trig(wc, 5'b11111, 0, 0, 0, 1'b0, '0);

      // Randomized triggers
      w = rnd_word();
      for (int i = 0; i < 60; i++) begin
         en = 5'($urandom);
         if ($urandom_range(0, 7) == 0) en = '0;
         case ($urandom_range(0, 3))
            0:       t_val = 0;
            1:       t_val = $urandom_range(1, 3);
            default: t_val = $urandom_range(4, 20);
         endcase
         for (int ch = 0; ch < 5; ch++) begin
            pa[ch] = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 22);
            if (t_val == 0 && pa[ch] < 0) pa[ch] = $urandom_range(0, 22);
         end
         stall  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
         gap    = $urandom_range(0, 3);
         show   = (i < 59) ? 1'($urandom) : 1'b0;
         w_next = rnd_word();
         do_trig(w, en, t_val, stall, gap, show, w_next);
         w = w_next;
      end

      // Reset while waiting for acquisition abandons the trigger
      p = (cyc_now + 1 > idle_at) ? cyc_now + 1 : idle_at;
      while (cyc_now < p - 1) begin
         tick();
         trig_fifo_valid = 1'b0;
         chan_acq_done   = '0;
         reset_counters  = 1'b0;
      end
      tick();
      trig_fifo_valid = 1'b1;
      trig_fifo_data  = rnd_word();
      chan_en         = 5'b11111;
      chan_acq_done   = '0;
      acq_timeout     = '0;
      reset_counters  = 1'b0;
      #1;
      check("rst_test_pop", 128'(trig_fifo_rd), 128'(1));
      repeat (2) begin
         tick();
         trig_fifo_valid = 1'b0;
      end
      tick();
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      rec_ready = 1'b1;
      #1;
      check("midrst_state", 128'(state), 128'(StIdle));
      check("midrst_valid", 128'(rec_valid), 128'(0));
      check("midrst_count", 128'(trig_proc_count), 128'(0));
      check("midrst_tmo_count", 128'(timeout_count), 128'(0));
      repeat (10) tick();
      idle_at = cyc_now + 1;
      shown   = 1'b0;

      // Normal operation after reset
      pa = '{-1, 2, -1, -1, -1};
      do_trig(rnd_word(), 5'b00010, 0, 3, 0, 1'b0, '0);
      repeat (5) begin
         tick();
         trig_fifo_valid = 1'b0;
         reset_counters  = 1'b0;
      end
      check("scoreboard_empty", 128'(sb_q.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_trigger_processor.md
Name: pulse_trigger_processor

Overview:
- Consumes the 128-bit trigger-info words from the Pulse Trigger FIFO, which is written by the front-panel trigger receiver in asynchronous mode.
- For each trigger, snapshots the enabled-channel mask and waits until every enabled channel reports acquisition complete, or until a programmable timeout expires.
- Emits one 128-bit trigger record per trigger to the readout-side record FIFO, which feeds the command manager / AMC13 event builder.
- Maintains processed-trigger and timeout counters for status readback.

Parameters:
- NCHAN, 5, number of digitizer channels.
- TMO_W, 16, width of the acquisition timeout counter.

Ports:
- clk  in  1  40 MHz TTC clock
- reset  in  1  synchronous, active-high
- reset_counters  in  1  clears trig_proc_count and timeout_count
- trig_fifo_valid  in  1  Pulse Trigger FIFO output non-empty (first-word-fall-through)
- trig_fifo_data  in  128  {58'd0, trig_length[1:0], trig_num[23:0], trig_timestamp[43:0]}
- trig_fifo_rd  out  1  pop strobe
- chan_en  in  NCHAN  enabled channels
- chan_acq_done  in  NCHAN  one-cycle pulse per channel when its burst acquisition finishes
- acq_timeout  in  TMO_W  timeout in clk cycles; 0 disables the timeout
- rec_valid  out  1  record available
- rec_ready  in  1  record FIFO can accept
- rec_data  out  128  trigger record
- trig_proc_count  out  32  records emitted
- timeout_count  out  32  records emitted with the timeout flag set
- state  out  4  one-hot FSM state

Behaviour:
- Reset: applies to all outputs and registers.
  - state = IDLE.
  - trig_fifo_rd, rec_valid = 0; rec_data = 0.
  - Both counters = 0; internal mask and timer = 0.
  - Reset mid-operation abandons the in-flight trigger. A word already popped is lost and no record is emitted.
- States, one-hot: IDLE, WAIT_ACQ, STORE, DRAIN.
- IDLE:
  - trig_fifo_rd = trig_fifo_valid; the pop is combinational from state and trig_fifo_valid.
  - On a pop in cycle N, latch in the same cycle:
    - trig_length, trig_num, timestamp;
    - en_l = chan_en;
    - done_l = chan_acq_done & chan_en, so a done pulse in the pop cycle counts;
    - timer = 0.
  - Next state: STORE if chan_en == 0, otherwise WAIT_ACQ.
- WAIT_ACQ:
  - Each cycle: done_l |= chan_acq_done & en_l, and timer increments.
  - Done pulses from channels not in en_l are ignored.
  - If (done_l | (chan_acq_done & en_l)) == en_l: go to STORE with tmo = 0.
  - Else if acq_timeout != 0 and timer == acq_timeout - 1: go to STORE with tmo = 1. Completion wins over timeout when both occur in the same cycle.
  - The timer saturates at all-ones and never wraps.
- STORE:
  - rec_valid = 1.
  - rec_data = {52'd0, tmo, done_mask[4:0], trig_length[1:0], trig_num[23:0], trig_timestamp[43:0]}, i.e. bits [43:0] timestamp, [67:44] trig_num, [69:68] length, [74:70] done mask, [75] timeout flag.
  - rec_data is registered and held stable while rec_valid is high and rec_ready is low.
  - Handshake on rec_valid & rec_ready:
    - trig_proc_count += 1;
    - timeout_count += tmo;
    - next state DRAIN.
- DRAIN (exactly one cycle):
  - rec_valid = 0, rec_data = 0.
  - Next state IDLE.
  - Exists so the FWFT FIFO output has settled before the next pop.
- Latency:
  - A pop at cycle N with all channels already done gives rec_valid at N+2.
  - A pop with chan_en == 0 gives rec_valid at N+1.
  - Back-to-back triggers: minimum 4 cycles per trigger.
- Counters:
  - Both counters wrap modulo 2^32.
  - reset_counters has priority over a same-cycle increment and does not affect the FSM.
- The upstream FIFO only empties through this block. rec_ready backpressure stalls in STORE indefinitely; no words are dropped here.

Decomposition:
- Shared package (pulse_trig_pkg):
  - one-hot state indices for IDLE, WAIT_ACQ, STORE, DRAIN;
  - rec_data field offsets and widths;
  - trig_length encodings: 00 none, 01 short, 10 long, 11 mixed;
  - NCHAN default.
- Single module. The done-mask and timer logic is small enough to stay inline; no sub-module.

Test Plan:
- chan_en = 5'b10101, FIFO word with trig_num = 7, ts = 0x123, length = 01; done pulses on ch0 @+3, ch2 @+5, ch4 @+9 -> one record, mask = 10101, tmo = 0, trig_num = 7, ts = 0x123, rec_valid in the cycle after the ch4 pulse; trig_proc_count = 1.
- acq_timeout = 10, chan_en = 5'b00011, only ch0 done -> STORE exactly 10 cycles after the pop, mask = 00001, tmo = 1, timeout_count = 1.
- chan_en = 0 -> rec_valid at N+1 with mask = 0, tmo = 0; done pulses on a disabled channel ch3 during WAIT_ACQ (chan_en = 00001) are ignored.
- rec_ready held low for 20 cycles in STORE -> rec_data unchanged throughout; no pop while stalled; counter increments only on the handshake.
- Three queued words, all channels done in the pop cycle -> records emitted every 4 cycles in trig_num order.
- reset asserted while in WAIT_ACQ -> IDLE next cycle, rec_valid = 0, counters = 0, no record emitted; reset_counters in the same cycle as a handshake -> count = 0.
